// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB3 requester: FSM states, response record, bus widths.
package apb_pkg;

   localparam int APB_AW          = 32;
   localparam int APB_DW          = 32;
   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   typedef struct packed {
      logic [APB_DW-1:0] rdata;
      logic              slverr;
      logic              timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the requester, with the requester-side
// (master) and the system/peripheral-side (slave) views.
interface apb_master_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;

   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: one valid/ready command becomes one SETUP/ACCESS transfer, and the
// slave result (or a timeout) is returned on the response channel. All outputs registered.
module apb_master
   import apb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int AW      = APB_AW,
   parameter int DW      = APB_DW
) (
   input logic          pclk,
   input logic          preset_n,
   apb_master_if.master bus
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_state_e    state_reg;
   logic [CW-1:0] wait_cnt_reg;
   logic          cmd_ready_reg;
   logic          psel_reg;
   logic          penable_reg;
   logic          pwrite_reg;
   logic [AW-1:0] paddr_reg;
   logic [DW-1:0] pwdata_reg;
   logic          rsp_valid_reg;
   apb_rsp_t      rsp_reg;
   logic          timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_LIMIT);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         cmd_ready_reg <= 1'b0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               cmd_ready_reg <= 1'b1;
               if (bus.cmd_valid && cmd_ready_reg) begin
                  pwrite_reg    <= bus.cmd_write;
                  paddr_reg     <= bus.cmd_addr;
                  pwdata_reg    <= bus.cmd_wdata;
                  wait_cnt_reg  <= '0;
                  cmd_ready_reg <= 1'b0;
                  psel_reg      <= 1'b1;
                  state_reg     <= SETUP;
               end
            end
            SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over an expiring wait limit.
               if (bus.pready) begin
                  rsp_reg       <= '{rdata:   pwrite_reg ? {APB_DW{1'b0}} : bus.prdata,
                                     slverr:  bus.pslverr,
                                     timeout: 1'b0};
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (timeout_hit) begin
                  rsp_reg       <= '{rdata: {APB_DW{1'b0}}, slverr: 1'b1, timeout: 1'b1};
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (wait_cnt_reg != {CW{1'b1}}) begin
                  wait_cnt_reg <= wait_cnt_reg + CW'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_reg;
   assign bus.psel        = psel_reg;
   assign bus.penable     = penable_reg;
   assign bus.pwrite      = pwrite_reg;
   assign bus.paddr       = paddr_reg;
   assign bus.pwdata      = pwdata_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_rdata   = rsp_reg.rdata;
   assign bus.rsp_slverr  = rsp_reg.slverr;
   assign bus.rsp_timeout = rsp_reg.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT = 4): a transaction-level timeline model drives
// expectations, a negedge process compares every output each cycle.
module tb_apb_master;

   localparam int TO_CYC = 4;

   logic pclk;
   logic preset_n;

   apb_master_if #(.AW(32), .DW(32)) bus ();

   apb_master #(.TIMEOUT(TO_CYC), .AW(32), .DW(32)) dut (
      .pclk    (pclk),
      .preset_n(preset_n),
      .bus     (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int total = 0;
   int bad   = 0;

   // expected outputs for the current cycle
   logic        exp_cmd_ready, exp_psel, exp_penable, exp_pwrite;
   logic [31:0] exp_paddr, exp_pwdata, exp_rdata;
   logic        exp_rsp_valid, exp_slverr, exp_timeout;
   logic        chk_en = 1'b0;

   // measurements taken by the compare process
   int cyc = 0;
   int acc_cyc = 0, acc_gap = 0, rsp_lat = 0, psel_cnt = 0, pen_cnt = 0;
   logic prev_rv = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge pclk) cyc <= cyc + 1;

   always @(negedge pclk) begin
      if (chk_en) begin
         check("cmd_ready",   bus.cmd_ready,   exp_cmd_ready);
         check("psel",        bus.psel,        exp_psel);
         check("penable",     bus.penable,     exp_penable);
         check("pwrite",      bus.pwrite,      exp_pwrite);
         check("paddr",       bus.paddr,       exp_paddr);
         check("pwdata",      bus.pwdata,      exp_pwdata);
         check("rsp_valid",   bus.rsp_valid,   exp_rsp_valid);
         check("rsp_rdata",   bus.rsp_rdata,   exp_rdata);
         check("rsp_slverr",  bus.rsp_slverr,  exp_slverr);
         check("rsp_timeout", bus.rsp_timeout, exp_timeout);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
         acc_gap  <= cyc - acc_cyc;
         acc_cyc  <= cyc;
         psel_cnt <= 0;
         pen_cnt  <= 0;
      end else begin
         psel_cnt <= psel_cnt + int'(bus.psel);
         pen_cnt  <= pen_cnt + int'(bus.penable);
      end
      if (bus.rsp_valid && !prev_rv) rsp_lat <= cyc - acc_cyc;
      prev_rv <= bus.rsp_valid;
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_exp();
      exp_cmd_ready = 1'b0; exp_psel = 1'b0; exp_penable = 1'b0; exp_pwrite = 1'b0;
      exp_paddr = '0; exp_pwdata = '0; exp_rdata = '0;
      exp_rsp_valid = 1'b0; exp_slverr = 1'b0; exp_timeout = 1'b0;
   endtask

   // One full transfer starting in an IDLE cycle with cmd_ready high. The slave holds
   // pready low for 'waits' ACCESS cycles; the response is held 'hold' cycles unconsumed.
   task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input int hold);
      bit to;
      int acc;
      to  = (waits >= TO_CYC);
      acc = to ? TO_CYC : waits + 1;
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
      tick();                                   // SETUP
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 32'hFFFF_FFFF;
      bus.cmd_wdata = 32'h0BAD_0BAD;
      exp_cmd_ready = 1'b0; exp_psel = 1'b1; exp_penable = 1'b0;
      exp_pwrite = wr; exp_paddr = addr; exp_pwdata = wdata;
      tick();                                   // ACCESS
      exp_penable = 1'b1;
      for (int i = 0; i < acc; i++) begin
         if (i > 0) tick();
         bus.pready  = (i == waits);
         bus.prdata  = rdata;
         bus.pslverr = slverr;
      end
      tick();                                   // RESP
      bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h5A5A_5A5A;
      exp_psel = 1'b0; exp_penable = 1'b0; exp_rsp_valid = 1'b1;
      exp_rdata   = (to || wr) ? 32'h0 : rdata;
      exp_slverr  = to || slverr;
      exp_timeout = to;
      bus.rsp_ready = (hold == 0);
      for (int j = 1; j <= hold; j++) begin
         tick();
         bus.rsp_ready = (j == hold);
      end
      tick();                                   // IDLE
      bus.rsp_ready = 1'b0;
      exp_rsp_valid = 1'b0; exp_cmd_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      preset_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
      clear_exp();
      chk_en = 1'b1;
      tick(); tick();
      preset_n = 1'b1;
      tick();
      exp_cmd_ready = 1'b1;
      check("cmd_ready_after_reset", bus.cmd_ready, 1);

      // zero-wait write
      run_xfer(1'b1, 32'h4, 32'hB3, 0, 32'hCAFE, 1'b0, 0);
      check("wr_latency", rsp_lat, 3);
      check("wr_psel_cycles", psel_cnt, 2);
      check("wr_penable_cycles", pen_cnt, 1);

      // read with 3 wait states, response held 2 extra cycles
      run_xfer(1'b0, 32'h8, 32'h0, 3, 32'hDEADBEEF, 1'b0, 2);
      check("rd_wait_access_cycles", pen_cnt, 4);
      check("rd_wait_latency", rsp_lat, 6);
      check("rd_wait_rdata_held", bus.rsp_rdata, 32'hDEADBEEF);

      // slave error
      run_xfer(1'b0, 32'h10, 32'h0, 0, 32'h1111, 1'b1, 0);
      check("slverr_flag", bus.rsp_slverr, 1);
      check("slverr_not_timeout", bus.rsp_timeout, 0);

      // timeout: pready stuck low
      run_xfer(1'b0, 32'h20, 32'h77, 100, 32'h5555, 1'b0, 0);
      check("to_access_cycles", pen_cnt, 4);
      check("to_latency", rsp_lat, TO_CYC + 2);
      check("to_flag", bus.rsp_timeout, 1);

      // pready rises exactly in the last allowed ACCESS cycle
      run_xfer(1'b0, 32'h24, 32'h0, 3, 32'h12345678, 1'b0, 0);
      check("edge_access_cycles", pen_cnt, 4);
      check("edge_no_timeout", bus.rsp_timeout, 0);
      check("edge_rdata", bus.rsp_rdata, 32'h12345678);

      // backpressure then immediate next command
      run_xfer(1'b1, 32'h30, 32'hA5A5, 0, 32'h0, 1'b0, 5);
      run_xfer(1'b1, 32'h34, 32'h5A5A, 0, 32'h0, 1'b0, 0);
      check("backpressure_gap", acc_gap, 9);
      run_xfer(1'b0, 32'h38, 32'h0, 0, 32'h0F0F, 1'b0, 0);
      check("back_to_back_gap", acc_gap, 4);

      // reset in the middle of ACCESS
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40; bus.cmd_wdata = 32'h99;
      tick();
      bus.cmd_valid = 1'b0;
      exp_cmd_ready = 1'b0; exp_psel = 1'b1; exp_penable = 1'b0;
      exp_pwrite = 1'b0; exp_paddr = 32'h40; exp_pwdata = 32'h99;
      tick();
      exp_penable = 1'b1; bus.pready = 1'b0;
      tick();
      #2;
      preset_n = 1'b0;
      #1;
      check("rst_psel_async", bus.psel, 0);
      check("rst_penable_async", bus.penable, 0);
      clear_exp();
      tick(); tick();
      preset_n = 1'b1;
      tick();
      exp_cmd_ready = 1'b1;
      check("rst_no_rsp_valid", bus.rsp_valid, 0);

      run_xfer(1'b0, 32'h44, 32'h0, 1, 32'hFEEDF00D, 1'b0, 1);
      check("post_rst_latency", rsp_lat, 4);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
